// File: rtl/split_mem_target.sv
// Memory-backed split-capable target: writes ack at once, reads are split and returned after READ_LATENCY.
// Optional address-range error reporting is enabled by defining SPLIT_MEM_TGT_ERR_EN.
//
// state   | meaning
// IDLE    | ready, waiting for an address strobe
// WR_DATA | write address latched, waiting for write data
// WR_ACK  | write done, one-cycle target_ack
// SPLIT   | read split off the bus, memory read, latency counter loaded
// LATENCY | counting down the read latency
// REQ     | requesting the bus for the read return
// SEND    | driving read data
// ACK     | read completion ack, bus released next cycle
module split_mem_target #(
   parameter int ADDR_WIDTH   = 12,
   parameter int READ_LATENCY = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [15:0] target_addr_in,
   input  logic       target_addr_in_valid,
   input  logic       target_rw,
   input  logic [7:0] target_data_in,
   input  logic       target_data_in_valid,
   input  logic       split_grant,
   output logic       target_ready,
   output logic       target_ack,
   output logic       target_split_ack,
   output logic       split_req,
   output logic [7:0] target_data_out,
`ifdef SPLIT_MEM_TGT_ERR_EN
   output logic       addr_err,
`endif
   output logic       target_data_out_valid
);

   typedef enum logic [2:0] {
      IDLE, WR_DATA, WR_ACK, SPLIT, LATENCY, REQ, SEND, ACK
   } state_t;

   state_t state, state_next;

   logic [7:0]            mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            data_q;
   logic [7:0]            cnt;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic                  addr_hi_bad;
   logic                  bad_q;

`ifdef SPLIT_MEM_TGT_ERR_EN
   assign addr_hi_bad = (target_addr_in[15:ADDR_WIDTH] != '0);
`else
   // Upper address bits alias when error reporting is compiled out.
   logic unused_addr_hi;
   assign unused_addr_hi = ^target_addr_in[15:ADDR_WIDTH];
   assign addr_hi_bad    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next            = state;
      target_ready          = 1'b0;
      target_ack            = 1'b0;
      target_split_ack      = 1'b0;
      split_req             = 1'b0;
      target_data_out_valid = 1'b0;
      case (state)
         IDLE: begin
            target_ready = 1'b1;
            if (target_addr_in_valid) begin
               if (!target_rw)                state_next = SPLIT;
               else if (target_data_in_valid) state_next = WR_ACK;
               else                           state_next = WR_DATA;
            end
         end
         WR_DATA: if (target_data_in_valid) state_next = WR_ACK;
         WR_ACK: begin
            target_ack = 1'b1;
            state_next = IDLE;
         end
         SPLIT: begin
            target_split_ack = 1'b1;
            state_next       = LATENCY;
         end
         LATENCY: if (cnt == 8'd0) state_next = REQ;
         REQ: begin
            split_req = 1'b1;
            if (split_grant) state_next = SEND;
         end
         SEND: begin
            split_req             = 1'b1;
            target_data_out_valid = 1'b1;
            state_next            = ACK;
         end
         ACK: begin
            split_req  = 1'b1;
            target_ack = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A write with data in the address cycle uses the live address; otherwise the latched one.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = addr_q;
      if (!rst) begin
         if (state == IDLE && target_addr_in_valid && target_rw && target_data_in_valid) begin
            mem_we    = !addr_hi_bad;
            mem_waddr = target_addr_in[ADDR_WIDTH-1:0];
         end else if (state == WR_DATA && target_data_in_valid) begin
            mem_we = !bad_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= target_data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q          <= '0;
         bad_q           <= 1'b0;
         data_q          <= 8'h00;
         cnt             <= 8'd0;
         target_data_out <= 8'h00;
      end else begin
         case (state)
            IDLE: if (target_addr_in_valid) begin
               addr_q <= target_addr_in[ADDR_WIDTH-1:0];
               bad_q  <= addr_hi_bad;
            end
            SPLIT: begin
               cnt    <= 8'(READ_LATENCY - 1);
               data_q <= bad_q ? 8'hFF : mem[addr_q];
            end
            LATENCY: if (cnt != 8'd0) cnt <= cnt - 8'd1;
            REQ: if (split_grant) target_data_out <= data_q;
            default: ;
         endcase
      end
   end

`ifdef SPLIT_MEM_TGT_ERR_EN
   always_ff @(posedge clk) begin
      if (rst) addr_err <= 1'b0;
      else if (state == IDLE && target_addr_in_valid && addr_hi_bad) addr_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_split_mem_target.sv
// Directed self-checking bench for split_mem_target (READ_LATENCY = 4, ADDR_WIDTH = 12).
module tb_split_mem_target;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] target_addr_in;
   logic        target_addr_in_valid;
   logic        target_rw;
   logic [7:0]  target_data_in;
   logic        target_data_in_valid;
   logic        split_grant;
   logic        target_ready;
   logic        target_ack;
   logic        target_split_ack;
   logic        split_req;
   logic [7:0]  target_data_out;
   logic        target_data_out_valid;
`ifdef SPLIT_MEM_TGT_ERR_EN
   logic        addr_err;
`endif

   int checks = 0;
   int errors = 0;
   int ack_cnt;
   int dov_cnt;
   logic [7:0] got_data;

   always #5 clk = ~clk;

   split_mem_target #(.ADDR_WIDTH(12), .READ_LATENCY(4)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .target_addr_in        (target_addr_in),
      .target_addr_in_valid  (target_addr_in_valid),
      .target_rw             (target_rw),
      .target_data_in        (target_data_in),
      .target_data_in_valid  (target_data_in_valid),
      .split_grant           (split_grant),
      .target_ready          (target_ready),
      .target_ack            (target_ack),
      .target_split_ack      (target_split_ack),
      .split_req             (split_req),
      .target_data_out       (target_data_out),
`ifdef SPLIT_MEM_TGT_ERR_EN
      .addr_err              (addr_err),
`endif
      .target_data_out_valid (target_data_out_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, got, exp);
      end
   endtask

   task automatic write_now(input logic [15:0] a, input logic [7:0] d);
      target_addr_in = a; target_rw = 1'b1; target_data_in = d;
      target_addr_in_valid = 1'b1; target_data_in_valid = 1'b1;
      tick();
      target_addr_in_valid = 1'b0; target_data_in_valid = 1'b0;
      tick();
   endtask

   task automatic start_read(input string name, input logic [15:0] a);
      target_addr_in = a; target_rw = 1'b0; target_addr_in_valid = 1'b1;
      tick();
      target_addr_in_valid = 1'b0;
      chk({name, "_split_ack"}, 16'(target_split_ack), 16'h1);
   endtask

   // Grants the bus as soon as it is requested; bounded so a stuck DUT still reaches the summary.
   task automatic finish_read(input string name, input logic [7:0] exp);
      ack_cnt = 0; dov_cnt = 0; got_data = 8'h00;
      for (int i = 0; i < 300; i++) begin
         split_grant = split_req;
         tick();
         if (target_data_out_valid) begin
            dov_cnt++;
            got_data = target_data_out;
         end
         if (target_ack) begin
            ack_cnt++;
            break;
         end
      end
      split_grant = 1'b0;
      tick();
      chk({name, "_dov_cnt"}, 16'(dov_cnt), 16'd1);
      chk({name, "_ack_cnt"}, 16'(ack_cnt), 16'd1);
      chk({name, "_data"}, 16'(got_data), 16'(exp));
      chk({name, "_ready_after"}, 16'(target_ready), 16'h1);
   endtask

   initial begin
      rst = 1'b1;
      target_addr_in = 16'h0; target_addr_in_valid = 1'b0; target_rw = 1'b0;
      target_data_in = 8'h0; target_data_in_valid = 1'b0; split_grant = 1'b0;
      tick(); tick();
      chk("rst_ready", 16'(target_ready), 16'h1);
      chk("rst_ack", 16'(target_ack), 16'h0);
      chk("rst_split_ack", 16'(target_split_ack), 16'h0);
      chk("rst_split_req", 16'(split_req), 16'h0);
      chk("rst_dov", 16'(target_data_out_valid), 16'h0);
      chk("rst_data_out", 16'(target_data_out), 16'h00);
      rst = 1'b0;
      tick();

      // Write with data in the address cycle
      target_addr_in = 16'h0123; target_rw = 1'b1; target_data_in = 8'hA5;
      target_addr_in_valid = 1'b1; target_data_in_valid = 1'b1;
      tick();
      target_addr_in_valid = 1'b0; target_data_in_valid = 1'b0;
      chk("wr_ack_t1", 16'(target_ack), 16'h1);
      chk("wr_ready_t1", 16'(target_ready), 16'h0);
      tick();
      chk("wr_ack_t2", 16'(target_ack), 16'h0);
      chk("wr_ready_t2", 16'(target_ready), 16'h1);

      // Split read with exact cycle timing; grant in T+8
      target_addr_in = 16'h0123; target_rw = 1'b0; target_addr_in_valid = 1'b1;
      tick();
      target_addr_in_valid = 1'b0;
      chk("rd_split_ack_t1", 16'(target_split_ack), 16'h1);
      chk("rd_ready_t1", 16'(target_ready), 16'h0);
      tick(); tick(); tick(); tick();
      chk("rd_split_req_t5", 16'(split_req), 16'h0);
      tick();
      chk("rd_split_req_t6", 16'(split_req), 16'h1);
      tick();
      chk("rd_dov_t7", 16'(target_data_out_valid), 16'h0);
      tick();
      chk("rd_split_req_t8", 16'(split_req), 16'h1);
      split_grant = 1'b1;
      tick();
      split_grant = 1'b0;
      chk("rd_dov_t9", 16'(target_data_out_valid), 16'h1);
      chk("rd_data_t9", 16'(target_data_out), 16'h00A5);
      chk("rd_ack_t9", 16'(target_ack), 16'h0);
      tick();
      chk("rd_ack_t10", 16'(target_ack), 16'h1);
      chk("rd_dov_t10", 16'(target_data_out_valid), 16'h0);
      chk("rd_split_req_t10", 16'(split_req), 16'h1);
      tick();
      chk("rd_split_req_t11", 16'(split_req), 16'h0);
      chk("rd_ready_t11", 16'(target_ready), 16'h1);
      chk("rd_data_hold", 16'(target_data_out), 16'h00A5);

      // Delayed write data
      target_addr_in = 16'h0FFF; target_rw = 1'b1; target_addr_in_valid = 1'b1;
      tick();
      target_addr_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("dly_no_ack", 16'(target_ack), 16'h0);
         chk("dly_busy", 16'(target_ready), 16'h0);
         tick();
      end
      target_data_in = 8'h3C; target_data_in_valid = 1'b1;
      tick();
      target_data_in_valid = 1'b0;
      chk("dly_ack", 16'(target_ack), 16'h1);
      tick();
      chk("dly_ready", 16'(target_ready), 16'h1);
      start_read("dly_rd", 16'h0FFF);
      finish_read("dly_rd", 8'h3C);

      // Address strobe during LATENCY is dropped
      write_now(16'h0001, 8'h11);
      start_read("busy_rd", 16'h0123);
      tick();
      target_addr_in = 16'h0001; target_rw = 1'b1; target_data_in = 8'h99;
      target_addr_in_valid = 1'b1; target_data_in_valid = 1'b1;
      tick();
      target_addr_in_valid = 1'b0; target_data_in_valid = 1'b0;
      finish_read("busy_rd", 8'hA5);
      start_read("busy_chk", 16'h0001);
      finish_read("busy_chk", 8'h11);

      // Reset while split_req is high aborts the read silently
      start_read("rst_rd", 16'h0FFF);
      for (int i = 0; i < 20 && !split_req; i++) tick();
      chk("rst_rd_req_seen", 16'(split_req), 16'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_rd_req_low", 16'(split_req), 16'h0);
      chk("rst_rd_ready", 16'(target_ready), 16'h1);
      ack_cnt = 0; dov_cnt = 0;
      split_grant = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (target_ack) ack_cnt++;
         if (target_data_out_valid) dov_cnt++;
         tick();
      end
      split_grant = 1'b0;
      chk("rst_rd_no_ack", 16'(ack_cnt), 16'd0);
      chk("rst_rd_no_dov", 16'(dov_cnt), 16'd0);

      // Upper-bit aliasing / address error
      write_now(16'h0005, 8'h22);
      write_now(16'h1005, 8'h77);
`ifdef SPLIT_MEM_TGT_ERR_EN
      chk("err_flag", 16'(addr_err), 16'h1);
      start_read("err_rd_lo", 16'h0005);
      finish_read("err_rd_lo", 8'h22);
      start_read("err_rd_hi", 16'h1005);
      finish_read("err_rd_hi", 8'hFF);
      chk("err_sticky", 16'(addr_err), 16'h1);
`else
      start_read("alias_rd", 16'h0005);
      finish_read("alias_rd", 8'h77);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/split_mem_target.md
Name: split_mem_target

Overview:
- Memory-backed split-capable target device. It is the responder behind a split target port: it receives the parallel address, data and rw that the port deserialises from the bus.
- Writes complete immediately with target_ack.
- Reads are answered with target_split_ack, which releases the bus. After a programmable latency the device requests the bus through split_req, waits for split_grant, and returns the byte followed by target_ack.

Parameters:
ADDR_WIDTH, 12, implemented address bits; memory holds 2**ADDR_WIDTH bytes.
READ_LATENCY, 4, cycles between split_ack and split_req assertion; legal range 1..255.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
target_addr_in  input  16  transaction address from the split target port.
target_addr_in_valid  input  1  address strobe; sampled only in IDLE.
target_rw  input  1  1 = write, 0 = read; sampled with target_addr_in_valid.
target_data_in  input  8  write data.
target_data_in_valid  input  1  write data strobe.
split_grant  input  1  bus granted to the split target.
target_ready  output  1  high only in IDLE.
target_ack  output  1  one-cycle completion pulse.
target_split_ack  output  1  one-cycle pulse signalling that a read has been split.
split_req  output  1  bus request for split read return.
target_data_out  output  8  read data.
target_data_out_valid  output  1  one-cycle read data strobe.

Behaviour:
- Interface clocking: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - State goes to IDLE.
  - target_ready=1.
  - All other outputs are 0, including target_data_out=8'h00.
  - The latency counter clears.
  - Memory contents are not reset.
- Reset asserted mid-transaction aborts the transaction with no pulse emitted. Any pending write that has not yet been performed is dropped.
- Address mapping: mem index = target_addr_in[ADDR_WIDTH-1:0]. Upper bits alias unless SPLIT_MEM_TGT_ERR_EN is defined.
- IDLE:
  - target_ready=1.
  - On target_addr_in_valid at edge T, latch the address and rw; target_ready drops in cycle T+1.
  - Write with target_data_in_valid also high at T: write memory at edge T, go to WR_ACK.
  - Write without data: go to WR_DATA.
  - Read: go to SPLIT.
- WR_DATA: wait for target_data_in_valid, then write the byte at that edge and go to WR_ACK. No timeout.
- WR_ACK: target_ack=1 for exactly this cycle, then IDLE.
- SPLIT:
  - target_split_ack=1 for one cycle.
  - Read mem[addr] into the data register.
  - Load the counter with READ_LATENCY-1.
  - Go to LATENCY.
- LATENCY: decrement each cycle; at 0 go to REQ. Time in LATENCY is exactly READ_LATENCY cycles.
- REQ:
  - split_req=1.
  - When split_grant is sampled high, go to SEND.
- SEND:
  - split_req stays 1.
  - target_data_out_valid=1 for one cycle with target_data_out=data register.
  - If split_grant is low in SEND, still complete; grant loss is not a device error.
  - Next state ACK.
- ACK:
  - target_ack=1 and split_req=1 for this cycle.
  - Next cycle split_req=0, IDLE.
- target_data_out holds the last read byte after SEND.
- Input strobes outside their sampling states are ignored. target_addr_in_valid while not in IDLE is dropped; no queueing.
- target_ack, target_split_ack and target_data_out_valid are never high in the same cycle.
- A read of an address written in the same edge it is sampled cannot occur; only one transaction is in flight.

Optional Feature:
Macro SPLIT_MEM_TGT_ERR_EN.
- Defined:
  - Adds output addr_err (1 bit, reset 0, sticky until rst).
  - If target_addr_in[15:ADDR_WIDTH] != 0 at sampling:
    - addr_err is set.
    - A write completes its handshake (WR_DATA/WR_ACK) but does not modify memory.
    - A read follows the full split sequence and returns 8'hFF.
- Not defined: no addr_err port; upper bits are ignored, so addresses alias.

Test Plan:
- Write with data: rst, then addr=16'h0123, rw=1, data=8'hA5, both valid at edge T -> target_ack high only in cycle T+1, target_ready low in T+1, high in T+2.
- Split read: after the above, read 16'h0123 (READ_LATENCY=4) at T -> split_ack at T+1; split_req rises at T+6; grant given at T+8 -> data_out_valid with 8'hA5 at T+9, target_ack at T+10, split_req low at T+11.
- Delayed write data: addr=16'h0FFF rw=1 alone, data 8'h3C 5 cycles later -> ack the cycle after the data; a subsequent read of 16'h0FFF returns 8'h3C.
- Busy drop: issue a read, then pulse addr_valid for write 16'h0001 during LATENCY -> no write and no extra ack; memory[1] unchanged.
- Reset mid-read: assert rst while split_req=1 -> next cycle split_req=0, target_ready=1; no data_out_valid and no ack ever for that read.
- Alias/err: write 8'h77 to 16'h1005, then read 16'h0005 -> returns 8'h77 without the macro. With the macro: returns the old value and addr_err=1; a read of 16'h1005 returns 8'hFF.
